// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// default parameter values.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_r;

    // count register: clear, saturating increment or hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter. Define SEQ_DET_REG_OUT_EN to register y_out.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             x_valid,
    input  logic             load_pat,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             clr_cnt,
    output logic             y_out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    state_t            state_r;
    logic [PAT_W-1:0]  pattern_r;
    logic [PAT_W-2:0]  history_r;
    logic [PAT_W-2:0]  hist_shift_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_inc_s;
    logic              armed_r;
    logic              match_s;

    // A two-bit pattern keeps a single history bit, so the shift degenerates.
    generate
        if (PAT_W == 2) begin : g_hist_one
            assign hist_shift_s = x_in;
        end else begin : g_hist_many
            assign hist_shift_s = {history_r[PAT_W-3:0], x_in};
        end
    endgenerate

    // fill saturates once a full window of prior bits is present
    always_comb begin
        fill_inc_s = fill_r;
        if (fill_r != FILL_MAX) begin
            fill_inc_s = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end else begin
            fill_inc_s = FILL_MAX;
        end
    end

    // Mealy match: the completing bit is compared in the cycle it arrives
    always_comb begin
        match_s = 1'b0;
        if ((state_r == ST_ARMED) && x_valid && !load_pat &&
            (fill_r == FILL_MAX) && ({history_r, x_in} == pattern_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // detector FSM: pattern capture, history shifting and fill tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pattern_r <= {PAT_W{1'b0}};
            history_r <= {(PAT_W-1){1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            armed_r   <= 1'b0;
        end else if (load_pat) begin
            state_r   <= ST_ARMED;
            pattern_r <= pat_in;
            history_r <= {(PAT_W-1){1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            armed_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    armed_r <= 1'b0;
                end
                ST_ARMED: begin
                    state_r <= ST_ARMED;
                    armed_r <= 1'b1;
                    if (x_valid) begin
                        // Non-overlap mode restarts from an empty window after a hit.
                        if (match_s && !overlap_en) begin
                            history_r <= {(PAT_W-1){1'b0}};
                            fill_r    <= {FILL_W{1'b0}};
                        end else begin
                            history_r <= hist_shift_s;
                            fill_r    <= fill_inc_s;
                        end
                    end else begin
                        history_r <= history_r;
                        fill_r    <= fill_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match_s),
        .clr   (clr_cnt),
        .count (match_count)
    );

`ifdef SEQ_DET_REG_OUT_EN
    logic y_r;

    // registered pulse, one cycle after the completing bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y_r <= 1'b0;
        end else begin
            y_r <= match_s;
        end
    end

    assign y_out = y_r;
`else
    assign y_out = match_s;
`endif

    assign armed = armed_r;

endmodule : seq_pattern_detector
